// File: rtl/sprite_slot_arbiter.sv
// Sprite slot arbiter.
// Grants one sprite producer per cycle, round-robin. It captures the granted descriptor into a
// shadow table and marks that slot dirty. On each vertical-blank pulse it walks every slot once
// and writes only the dirty ones to the sprite RAM, so the renderer never sees a torn frame.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   req           per-requester write request, held until granted
//   req_addr      packed slot addresses, requester i at [i*AW +: AW]
//   req_data      packed descriptors, requester i at [i*DW +: DW]
//   gnt           one-hot combinational grant (capture happens at this edge)
//   vblank_start  single-cycle start-of-vertical-blank pulse
//   ram_we/ram_addr/ram_din  registered sprite RAM write port
//   busy          high while the flush is running
//   overrun       sticky, set by a vblank pulse that arrives mid-flush
module sprite_slot_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  input  logic               vblank_start,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_din,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned NSLOT = 2 ** AW;
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [NSLOT-1:0]  dirty_q;
  logic [DW-1:0]     shadow_q [NSLOT];

  logic              gnt_valid;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     cand;
  logic [AW-1:0]     gnt_addr;
  logic [DW-1:0]     gnt_data;

  // Grant search starts just after the last winner, so a continuously requesting producer
  // can never be starved.
  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (state_q == StIdle) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        cand = PW'((int'(rr_ptr_q) + k) % int'(NREQ));
        if (!gnt_valid && req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
      if (gnt_valid) gnt[gnt_idx] = 1'b1;
      if (vblank_start) state_d = StFlush;
    end else if (idx_q == AW'(NSLOT - 1)) begin
      state_d = StIdle;
    end
  end

  assign gnt_addr = req_addr[gnt_idx*AW +: AW];
  assign gnt_data = req_data[gnt_idx*DW +: DW];
  assign busy     = (state_q == StFlush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rr_ptr_q <= PW'(NREQ - 1);
      dirty_q  <= '1;  // first flush clears the whole RAM
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      overrun  <= 1'b0;
      for (int s = 0; s < int'(NSLOT); s++) shadow_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        ram_we <= 1'b0;
        // A grant on the vblank edge still lands before the flush walks slot 0.
        if (gnt_valid) begin
          shadow_q[gnt_addr] <= gnt_data;
          dirty_q[gnt_addr]  <= 1'b1;
          rr_ptr_q           <= gnt_idx;
        end
        if (vblank_start) idx_q <= '0;
      end else begin
        if (vblank_start) overrun <= 1'b1;
        if (dirty_q[idx_q]) begin
          ram_we         <= 1'b1;
          ram_addr       <= idx_q;
          ram_din        <= shadow_q[idx_q];
          dirty_q[idx_q] <= 1'b0;
        end else begin
          ram_we <= 1'b0;
        end
        idx_q <= idx_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_slot_arbiter.sv
module tb_sprite_slot_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [11:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         vblank_start;
  logic         ram_we;
  logic [2:0]   ram_addr;
  logic [31:0]  ram_din;
  logic         busy;
  logic         overrun;

  sprite_slot_arbiter #(.NREQ(4), .AW(3), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .gnt          (gnt),
    .vblank_start (vblank_start),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       vb;
    logic [3:0] gnt;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench model: shadow table, dirty flags, flush counter, sticky overrun.
  logic [31:0] m_shadow [8];
  logic [7:0]  m_dirty;
  int          flush_left;
  logic        m_overrun;
  wr_t         exp_q [$];
  logic [2:0]  t_addr [4];
  logic [31:0] t_data [4];
  vec_t        tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) m_shadow[s] = '0;
    m_dirty    = 8'hFF;
    flush_left = 0;
    m_overrun  = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: every RAM write must match the next expected write.
  always @(negedge clk) begin
    if (!reset && ram_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                 ram_addr, ram_din);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (ram_addr !== w.addr || ram_din !== w.data) begin
          n_fail++;
          $display("FAIL ram_write: got addr %0d data %h, expected addr %0d data %h",
                   ram_addr, ram_din, w.addr, w.data);
        end
      end
    end
  end

  // One clock cycle: drive at the falling edge, check, then advance the model past the
  // following rising edge.
  task automatic drive(input logic [3:0] r, input logic vb, input logic [3:0] eg,
                       input logic eb, input string nm);
    @(negedge clk);
    req          = r;
    vblank_start = vb;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*3 +: 3]   = t_addr[i];
      req_data[i*32 +: 32] = t_data[i];
    end
    #1;
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_busy"}, 32'(busy), 32'(eb));
    chk({nm, "_overrun"}, 32'(overrun), 32'(m_overrun));
    if (flush_left > 0) begin
      if (vb) m_overrun = 1'b1;
      flush_left--;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          m_shadow[t_addr[i]] = t_data[i];
          m_dirty[t_addr[i]]  = 1'b1;
        end
      end
      if (vb) begin
        for (int s = 0; s < 8; s++) begin
          if (m_dirty[s]) exp_q.push_back('{addr: 3'(s), data: m_shadow[s]});
        end
        m_dirty    = '0;
        flush_left = 8;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    req          = '0;
    vblank_start = 1'b0;
    #1;
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic [3:0] r, input logic vb, input logic [3:0] g, input logic b);
    tbl.push_back('{req: r, vb: vb, gnt: g, busy: b});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    req          = '0;
    req_addr     = '0;
    req_data     = '0;
    vblank_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_addr[i] = '0;
      t_data[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // Initial flush clears all 8 slots; slot 0 appears after the second edge.
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t1_idle");
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, "t1_vb");
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, "t1_f0");
    chk("t1_we_latency", 32'(ram_we), 32'd0);
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, "t1_f1");
    chk("t1_first_we", 32'(ram_we), 32'd1);
    chk("t1_first_addr", 32'(ram_addr), 32'd0);
    for (int k = 2; k < 8; k++) drive(4'b0000, 1'b0, 4'b0000, 1'b1, "t1_f");
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t1_end");
    chk("t1_last_addr", 32'(ram_addr), 32'd7);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    // Round-robin table, then a flush of the 4 dirty slots.
    t_addr[0] = 3'd1; t_addr[1] = 3'd3; t_addr[2] = 3'd4; t_addr[3] = 3'd6;
    for (int k = 0; k < 2; k++) begin
      add(4'b1111, 1'b0, 4'b0001, 1'b0);
      add(4'b1111, 1'b0, 4'b0010, 1'b0);
      add(4'b1111, 1'b0, 4'b0100, 1'b0);
      add(4'b1111, 1'b0, 4'b1000, 1'b0);
    end
    add(4'b0000, 1'b0, 4'b0000, 1'b0);
    add(4'b1010, 1'b0, 4'b0010, 1'b0);
    add(4'b1010, 1'b0, 4'b1000, 1'b0);
    add(4'b0100, 1'b0, 4'b0100, 1'b0);
    add(4'b0011, 1'b0, 4'b0001, 1'b0);
    add(4'b1001, 1'b0, 4'b1000, 1'b0);
    add(4'b1001, 1'b0, 4'b0001, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) add(4'b0000, 1'b0, 4'b0000, 1'b1);
    add(4'b0000, 1'b0, 4'b0000, 1'b0);
    for (int j = 0; j < tbl.size(); j++) begin
      for (int i = 0; i < 4; i++) t_data[i] = 32'hA000_0000 + 32'(j << 8) + 32'(i);
      drive(tbl[j].req, tbl[j].vb, tbl[j].gnt, tbl[j].busy, $sformatf("t2_v%0d", j));
    end
    chk("t2_pending", 32'(exp_q.size()), 32'd0);

    // Same slot twice before a flush: one write with the later descriptor.
    t_addr[1] = 3'd5; t_data[1] = 32'h8000_1234;
    drive(4'b0010, 1'b0, 4'b0010, 1'b0, "t3_w1");
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t3_gap");
    t_data[1] = 32'h8000_5678;
    drive(4'b0010, 1'b0, 4'b0010, 1'b0, "t3_w2");
    chk("t3_queued", 32'(exp_q.size()), 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, "t3_vb");
    chk("t3_one_write", 32'(exp_q.size()), 32'd1);
    for (int k = 0; k < 8; k++) drive(4'b0000, 1'b0, 4'b0000, 1'b1, "t3_f");
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t3_end");
    chk("t3_pending", 32'(exp_q.size()), 32'd0);

    // Request stalls during flush; second vblank mid-flush sets overrun.
    t_addr[2] = 3'd7; t_data[2] = 32'h0BAD_F00D;
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_vb");
    drive(4'b0100, 1'b0, 4'b0000, 1'b1, "t4_f0");
    drive(4'b0100, 1'b0, 4'b0000, 1'b1, "t4_f1");
    drive(4'b0100, 1'b1, 4'b0000, 1'b1, "t4_f2_vb");
    for (int k = 3; k < 8; k++) drive(4'b0100, 1'b0, 4'b0000, 1'b1, "t4_f");
    drive(4'b0100, 1'b0, 4'b0100, 1'b0, "t4_grant");
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t4_idle");
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_no_writes", 32'(exp_q.size()), 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_vb2");
    for (int k = 0; k < 8; k++) drive(4'b0000, 1'b0, 4'b0000, 1'b1, "t4_f2");
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t4_end");
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // Reset while idx=4 aborts the flush; next flush clears every slot.
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, "t5_vb");
    for (int k = 0; k < 4; k++) drive(4'b0000, 1'b0, 4'b0000, 1'b1, "t5_f");
    do_reset();
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t5_idle");
    chk("t5_no_we", 32'(ram_we), 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, "t5_vb2");
    chk("t5_clear_count", 32'(exp_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) drive(4'b0000, 1'b0, 4'b0000, 1'b1, "t5_f2");
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, "t5_end");
    chk("t5_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
